// File: rtl/spart_driver_if.sv
// SPART bus-control bundle: status inputs, chip-select/direction/address strobes
// and the shared bidirectional databus between the processor stand-in and the SPART.
interface spart_driver_if;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;

  modport master (
    input  rda,
    input  tbr,
    output iocs,
    output iorw,
    output ioaddr,
    inout  databus
  );

  modport slave (
    output rda,
    output tbr,
    input  iocs,
    input  iorw,
    input  ioaddr,
    inout  databus
  );
endinterface

// File: rtl/spart_driver.sv
// Processor stand-in for the SPART echo demo: programs the baud divisor, then echoes bytes.
// Optional DRIVER_BR_RECONFIG_EN: a br_cfg change while idle/waiting reruns the divisor init.
module spart_driver (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         br_cfg,
  spart_driver_if.master     bus,
  output logic [1:0]         o_dbg_state
);

  // Bus handshake: iocs=1 marks a one-clock bus cycle; iorw=1 reads (SPART drives,
  // captured at the rising edge), iorw=0 writes (this block drives databus).
  typedef enum logic [1:0] {
    S_INIT_LO  = 2'd0,
    S_INIT_HI  = 2'd1,
    S_IDLE     = 2'd2,
    S_WAIT_TBR = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_rx_byte;
  logic [7:0]  r_div_hi;
  logic [15:0] w_div_lut;
  logic        w_cs;
  logic        w_rw;
  logic [1:0]  w_addr;
  logic [7:0]  w_wdata;
  logic        w_rd_strobe;
  logic        w_cfg_change;

  always_comb begin
    case (br_cfg)
      2'b00:   w_div_lut = 16'd650;
      2'b01:   w_div_lut = 16'd325;
      2'b10:   w_div_lut = 16'd162;
      default: w_div_lut = 16'd80;
    endcase
  end

`ifdef DRIVER_BR_RECONFIG_EN
  logic [1:0] r_br_cfg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_br_cfg <= 2'b00;
    else     r_br_cfg <= br_cfg;
  end

  assign w_cfg_change = (br_cfg != r_br_cfg);
`else
  assign w_cfg_change = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_cs        = 1'b0;
    w_rw        = 1'b1;
    w_addr      = 2'b00;
    w_wdata     = 8'h00;
    w_rd_strobe = 1'b0;
    case (r_state)
      S_INIT_LO: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_addr  = 2'b10;
        w_wdata = w_div_lut[7:0];
        w_next  = S_INIT_HI;
      end
      S_INIT_HI: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_addr  = 2'b11;
        w_wdata = r_div_hi;
        w_next  = S_IDLE;
      end
      S_IDLE: begin
        if (bus.rda) begin
          w_cs        = 1'b1;
          w_rd_strobe = 1'b1;
          w_next      = S_WAIT_TBR;
        end else if (w_cfg_change) begin
          w_next = S_INIT_LO;
        end
      end
      default: begin
        if (bus.tbr) begin
          w_cs    = 1'b1;
          w_rw    = 1'b0;
          w_wdata = r_rx_byte;
          w_next  = S_IDLE;
        end else if (w_cfg_change) begin
          w_next = S_INIT_LO;
        end
      end
    endcase
    // Reset releases the bus immediately, independent of the registered state.
    if (rst) begin
      w_cs        = 1'b0;
      w_rw        = 1'b1;
      w_addr      = 2'b00;
      w_rd_strobe = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT_LO;
      r_rx_byte <= 8'h00;
      r_div_hi  <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT_LO) r_div_hi <= w_div_lut[15:8];
      if (w_rd_strobe)          r_rx_byte <= bus.databus;
    end
  end

  assign bus.iocs    = w_cs;
  assign bus.iorw    = w_rw;
  assign bus.ioaddr  = w_addr;
  assign bus.databus = (w_cs && !w_rw) ? w_wdata : 8'hzz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: directed vector table, hand sequences for reset/reconfig,
// and randomized traffic checked against a queue-based reference model.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic [1:0] dbg_state;
  logic       tb_en;
  logic [7:0] tb_data;

  spart_driver_if sif ();

  assign sif.databus = tb_en ? tb_data : 8'hzz;

  spart_driver dut (
    .clk         (clk),
    .rst         (rst),
    .br_cfg      (br_cfg),
    .bus         (sif.master),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: init progress, latched baud select, and bytes awaiting echo.
  logic [7:0] exp_q[$];
  int         m_init;
  logic [1:0] m_br;
  logic [1:0] m_prev_br;

  typedef struct {
    logic       rda;
    logic       tbr;
    logic [7:0] d;
    logic       e_cs;
    logic       e_rw;
    logic [1:0] e_a;
    logic [7:0] e_d;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] div_of(input logic [1:0] b);
    case (b)
      2'b00:   return 16'h028A;
      2'b01:   return 16'h0145;
      2'b10:   return 16'h00A2;
      default: return 16'h0050;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init    = 0;
    m_prev_br = 2'b00;
    exp_q.delete();
  endtask

  // Called just after a falling edge; holds reset for two clocks, then releases it.
  task automatic do_reset(input logic [1:0] br);
    rst     = 1'b1;
    br_cfg  = br;
    sif.rda = 1'b0;
    sif.tbr = 1'b0;
    tb_en   = 1'b1;
    tb_data = 8'($urandom);
    #1;
    chk("rst_iocs", {15'd0, sif.iocs}, 16'd0);
    chk("rst_iorw", {15'd0, sif.iorw}, 16'd1);
    chk("rst_addr", {14'd0, sif.ioaddr}, 16'd0);
    chk("rst_bus", {8'd0, sif.databus}, {8'd0, tb_data});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic apply_vec(input vec_t v);
    logic wr;
    wr      = v.e_cs && !v.e_rw;
    sif.rda = v.rda;
    sif.tbr = v.tbr;
    tb_data = v.d;
    tb_en   = !wr;
    #1;
    chk("vec_iocs", {15'd0, sif.iocs}, {15'd0, v.e_cs});
    chk("vec_iorw", {15'd0, sif.iorw}, {15'd0, v.e_rw});
    chk("vec_addr", {14'd0, sif.ioaddr}, {14'd0, v.e_a});
    chk("vec_bus", {8'd0, sif.databus}, {8'd0, (wr ? v.e_d : v.d)});
    @(negedge clk);
  endtask

  // One clock of stimulus; expectations come from the reference model.
  task automatic cycle(input logic r, input logic t, input logic [7:0] d);
    logic       e_cs;
    logic       e_rw;
    logic [1:0] e_a;
    logic [7:0] e_d;
    logic [15:0] dv;
    e_cs = 1'b0;
    e_rw = 1'b1;
    e_a  = 2'b00;
    e_d  = 8'h00;
    sif.rda = r;
    sif.tbr = t;
    tb_data = d;
    if (m_init == 0) begin
      m_br = br_cfg;
      dv   = div_of(br_cfg);
      e_cs = 1'b1; e_rw = 1'b0; e_a = 2'b10; e_d = dv[7:0];
      m_init = 1;
    end else if (m_init == 1) begin
      dv   = div_of(m_br);
      e_cs = 1'b1; e_rw = 1'b0; e_a = 2'b11; e_d = dv[15:8];
      m_init = 2;
    end else if (exp_q.size() == 0 && r) begin
      e_cs = 1'b1;
      exp_q.push_back(d);
    end else if (exp_q.size() != 0 && t) begin
      e_cs = 1'b1; e_rw = 1'b0;
      e_d  = exp_q.pop_front();
    end else begin
`ifdef DRIVER_BR_RECONFIG_EN
      if (br_cfg != m_prev_br) begin
        m_init = 0;
        exp_q.delete();
      end
`endif
    end
    m_prev_br = br_cfg;
    tb_en = !(e_cs && !e_rw);
    #1;
    chk("iocs", {15'd0, sif.iocs}, {15'd0, e_cs});
    chk("iorw", {15'd0, sif.iorw}, {15'd0, e_rw});
    chk("ioaddr", {14'd0, sif.ioaddr}, {14'd0, e_a});
    chk("databus", {8'd0, sif.databus}, {8'd0, (tb_en ? d : e_d)});
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 8'h8A};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b11, 8'h02};
    vecs[2]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 2'b00, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 2'b00, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 2'b00, 8'hFF};
    vecs[5]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 2'b00, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 2'b00, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 2'b00, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2'b00, 8'h5A};
    vecs[11] = '{1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 2'b00, 8'h00};

    rst     = 1'b1;
    br_cfg  = 2'b00;
    sif.rda = 1'b0;
    sif.tbr = 1'b0;
    tb_en   = 1'b1;
    tb_data = 8'h00;
    @(negedge clk);

    do_reset(2'b00);
    for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

    // Divisor init for the remaining baud selects.
    for (int b = 1; b < 4; b++) begin
      do_reset(2'(b));
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h9C);
    end

    // Reset during WAIT_TBR: immediate release, init reruns, old byte never sent.
    do_reset(2'b01);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'hC3);
    cycle(1'b0, 1'b0, 8'h10);
    sif.tbr = 1'b1;
    tb_en   = 1'b0;
    #2;
    rst     = 1'b1;
    tb_en   = 1'b1;
    tb_data = 8'h3C;
    #1;
    chk("abort_iocs", {15'd0, sif.iocs}, 16'd0);
    chk("abort_iorw", {15'd0, sif.iorw}, 16'd1);
    chk("abort_bus", {8'd0, sif.databus}, 16'h003C);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h66);

    // br_cfg change while idle: reprogram only when reconfiguration is built in.
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h01);
    br_cfg = 2'b11;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h02);

    // Randomized traffic with periodic resets on random baud selects.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) do_reset(2'($urandom_range(0, 3)));
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
# spart_driver

Processor-side stand-in for the mini SPART (special-purpose async receiver/transmitter) echo demo. After reset it programs the SPART baud-rate divisor from the board switches. It then runs an endless echo loop: wait for a received byte, read it over the shared bidirectional databus, wait for the transmit buffer to be free, write the byte back. It sits beside the SPART at top level and owns the SPART bus-control signals.

## Interface
- No parameters; divisor values are fixed for a 50 MHz clk.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready
- iocs  out  1  SPART chip select, 1 = bus cycle this clock
- iorw  out  1  1 = read from SPART, 0 = write to SPART
- ioaddr  out  2  00 = Tx/Rx buffer, 01 = status, 10 = divisor low, 11 = divisor high
- databus  inout  8  shared data bus; driven only when iocs=1 and iorw=0, otherwise 8'hzz

## Operation
- Divisor lookup by br_cfg: 00 -> 16'd650 (0x028A), 01 -> 16'd325 (0x0145), 10 -> 16'd162 (0x00A2), 11 -> 16'd80 (0x0050).
- The lookup is sampled in INIT_LO and held for INIT_HI.
- Internal 8-bit register rx_byte holds the received character.
- States and outputs:
  - INIT_LO: iocs=1, iorw=0, ioaddr=10, databus=div[7:0]; always -> INIT_HI.
  - INIT_HI: iocs=1, iorw=0, ioaddr=11, databus=div[15:8]; always -> IDLE.
  - IDLE: if rda=1, read cycle this same clock: iocs=1, iorw=1, ioaddr=00; rx_byte <= databus at the edge; -> WAIT_TBR. If rda=0: iocs=0, iorw=1, ioaddr=00, bus released.
  - WAIT_TBR: if tbr=1, write cycle this clock: iocs=1, iorw=0, ioaddr=00, databus=rx_byte; -> IDLE. If tbr=0: idle outputs, stay.
- The read and write strobes are Mealy (combinational on rda/tbr). Each is exactly one clock wide.
- rda is ignored outside IDLE. tbr is ignored outside WAIT_TBR.
- A byte arriving while in WAIT_TBR is not read until the echo completes.

## Timing
- Reset (async): state=INIT_LO, rx_byte=8'h00. While rst=1, outputs are forced to iocs=0, iorw=1, ioaddr=00, databus=hi-Z.
- First clock after rst deasserts: divisor-low write. Second clock: divisor-high write. From the third clock the block is in IDLE.
- Read latency: data must be valid on databus in the same cycle rda=1; it is captured at that rising edge.
- Echo latency: the write occurs on the first clock after the read in which tbr=1. Minimum is one clock after the read.
- Simultaneous rda and tbr in IDLE: only the read is performed.
- rst asserted mid-operation: immediate abort, bus released, the init sequence reruns after release.
- There is never bus contention from this block: databus is tri-stated in every cycle with iorw=1 or iocs=0.

## Configuration
- DRIVER_BR_RECONFIG_EN defined:
  - The block registers br_cfg each clock.
  - A change in br_cfg detected while in IDLE (rda=0) or WAIT_TBR (tbr=0) sends the FSM to INIT_LO, reprogramming the divisor.
  - Any pending rx_byte echo is dropped.
- Not defined: br_cfg is sampled only during the post-reset init sequence; later changes are ignored until the next reset.

## Test plan
- Reset with br_cfg=00 -> outputs iocs=0, iorw=1, bus Z. After release: cycle 1 iocs=1, iorw=0, ioaddr=10, databus=8'h8A; cycle 2 ioaddr=11, databus=8'h02; then iocs=0.
- Repeat init for br_cfg=01/10/11 -> low/high bytes 45/01, A2/00, 50/00.
- In IDLE, tbr=1: drive databus=8'hFF with rda=1 for one clock -> that clock iocs=1, iorw=1, ioaddr=00. Next clock iocs=1, iorw=0, ioaddr=00, databus=8'hFF. Then iocs=0.
- Read 8'h5A with tbr=0 held 3 clocks -> iocs=0 during the wait. Write of 8'h5A occurs on the clock tbr rises. rda pulses during the wait cause no read.
- rst asserted during WAIT_TBR -> bus Z immediately, init writes repeat, and the old byte is never transmitted.
- With DRIVER_BR_RECONFIG_EN, change br_cfg 00->11 in IDLE -> divisor writes 50/00 follow. Without the macro -> no bus activity.
